cursor_drawer: RTL and testbench

- Consumes the PS/2 mouse decoder outputs (x, y, l_click) and renders a square cursor into the VGA adapter pixel port, one pixel per cycle.
- On each cursor change it erases the old cursor by plotting background colour, then draws the cursor at the new position.
- Also emits a one-cycle click event with clamped coordinates for the hit-detection logic downstream.
- Mouse outputs are already registered in the clock domain, so no synchronisers are needed.

---
 rtl/cursor_pkg.sv | 22 ++
 rtl/cursor_scan.sv | 33 +++
 rtl/cursor_drawer.sv | 150 +++++++++++++++
 tb/tb_cursor_drawer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cursor_pkg.sv
// Shared definitions for the cursor renderer: FSM encoding, default colours,
// VGA coordinate widths and the coordinate clamp helper.
package cursor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DRAW  = 2'd2
  } state_t;

  localparam int VGA_X_W = 8;
  localparam int VGA_Y_W = 7;

  localparam logic [2:0] DEF_CURSOR_COLOUR = 3'b111;
  localparam logic [2:0] DEF_CLICK_COLOUR  = 3'b100;
  localparam logic [2:0] DEF_BG_COLOUR     = 3'b000;

  function automatic logic [8:0] clamp_coord(input logic [8:0] v, input logic [8:0] limit);
    return (v > limit) ? limit : v;
  endfunction

endpackage

// File: rtl/cursor_scan.sv
// dx/dy raster counter over a SIZE x SIZE square, dy outer and dx inner.
// Shared by the erase and draw passes.
module cursor_scan #(
  parameter int SIZE = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       advance,
  output logic [3:0] dx,
  output logic [3:0] dy,
  output logic       last
);

  localparam logic [3:0] LAST_IDX = 4'(SIZE - 1);

  assign last = (dx == LAST_IDX) && (dy == LAST_IDX);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      dx <= 4'd0;
      dy <= 4'd0;
    end else if (advance) begin
      if (dx == LAST_IDX) begin
        dx <= 4'd0;
        dy <= (dy == LAST_IDX) ? 4'd0 : dy + 4'd1;
      end else begin
        dx <= dx + 4'd1;
      end
    end
  end

endmodule

// File: rtl/cursor_drawer.sv
// Renders a square mouse cursor into the VGA pixel port (erase old, draw new)
// and emits a clamped click event on each left-button press.
module cursor_drawer
  import cursor_pkg::*;
#(
  parameter int         SCREEN_WIDTH  = 160,
  parameter int         SCREEN_HEIGHT = 120,
  parameter int         CURSOR_SIZE   = 5,
  parameter logic [2:0] CURSOR_COLOUR = DEF_CURSOR_COLOUR,
  parameter logic [2:0] CLICK_COLOUR  = DEF_CLICK_COLOUR,
  parameter logic [2:0] BG_COLOUR     = DEF_BG_COLOUR
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [8:0]         mouse_x,
  input  logic [8:0]         mouse_y,
  input  logic               l_click,
  input  logic               enable,
  output logic [VGA_X_W-1:0] vga_x,
  output logic [VGA_Y_W-1:0] vga_y,
  output logic [2:0]         vga_colour,
  output logic               vga_plot,
  output logic               busy,
  output logic               click_pulse,
  output logic [VGA_X_W-1:0] click_x,
  output logic [VGA_Y_W-1:0] click_y
);

  localparam logic [8:0] X_MAX = 9'(SCREEN_WIDTH - 1);
  localparam logic [8:0] Y_MAX = 9'(SCREEN_HEIGHT - 1);

  state_t             state_reg;
  logic               drawn_reg;
  logic [VGA_X_W-1:0] old_x_reg, new_x_reg;
  logic [VGA_Y_W-1:0] old_y_reg, new_y_reg;
  logic               old_click_reg, new_click_reg;
  logic               prev_click_reg;

  logic [VGA_X_W-1:0] cx;
  logic [VGA_Y_W-1:0] cy;
  logic               update;
  logic               click_rise;

  logic [3:0]         dx, dy;
  logic               scan_last;
  logic               scan_clear, scan_advance;

  logic [VGA_X_W-1:0] base_x;
  logic [VGA_Y_W-1:0] base_y;
  logic [8:0]         px, py;
  logic               on_screen;
  logic [2:0]         pix_colour;

  assign cx = VGA_X_W'(clamp_coord(mouse_x, X_MAX));
  assign cy = VGA_Y_W'(clamp_coord(mouse_y, Y_MAX));

  assign update = enable && (!drawn_reg || (cx != old_x_reg) || (cy != old_y_reg)
                             || (l_click != old_click_reg));
  assign click_rise = l_click && !prev_click_reg;

  // Counter sits at zero while idle so every pass starts at (0,0).
  assign scan_clear   = (state_reg == IDLE) || (enable && scan_last);
  assign scan_advance = enable && (state_reg != IDLE);

  cursor_scan #(.SIZE(CURSOR_SIZE)) u_scan (
    .clock   (clock),
    .reset   (reset),
    .clear   (scan_clear),
    .advance (scan_advance),
    .dx      (dx),
    .dy      (dy),
    .last    (scan_last)
  );

  assign base_x     = (state_reg == ERASE) ? old_x_reg : new_x_reg;
  assign base_y     = (state_reg == ERASE) ? old_y_reg : new_y_reg;
  // 9-bit sums so pixels past the right/bottom edge are detected, not wrapped.
  assign px         = {1'b0, base_x} + {5'd0, dx};
  assign py         = {2'b0, base_y} + {5'd0, dy};
  assign on_screen  = (px < 9'(SCREEN_WIDTH)) && (py < 9'(SCREEN_HEIGHT));
  assign pix_colour = (state_reg == ERASE) ? BG_COLOUR
                    : (new_click_reg ? CLICK_COLOUR : CURSOR_COLOUR);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      drawn_reg      <= 1'b0;
      old_x_reg      <= '0;
      old_y_reg      <= '0;
      old_click_reg  <= 1'b0;
      new_x_reg      <= '0;
      new_y_reg      <= '0;
      new_click_reg  <= 1'b0;
      prev_click_reg <= 1'b0;
      vga_x          <= '0;
      vga_y          <= '0;
      vga_colour     <= 3'b000;
      vga_plot       <= 1'b0;
      busy           <= 1'b0;
      click_pulse    <= 1'b0;
      click_x        <= '0;
      click_y        <= '0;
    end else begin
      prev_click_reg <= l_click;
      click_pulse    <= click_rise;
      if (click_rise) begin
        click_x <= cx;
        click_y <= cy;
      end

      vga_plot <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (update) begin
            new_x_reg     <= cx;
            new_y_reg     <= cy;
            new_click_reg <= l_click;
            state_reg     <= drawn_reg ? ERASE : DRAW;
            busy          <= 1'b1;
          end
        end
        ERASE, DRAW: begin
          if (enable) begin
            vga_x      <= px[VGA_X_W-1:0];
            vga_y      <= py[VGA_Y_W-1:0];
            vga_colour <= pix_colour;
            vga_plot   <= on_screen;
            if (scan_last) begin
              if (state_reg == ERASE) begin
                state_reg <= DRAW;
              end else begin
                old_x_reg     <= new_x_reg;
                old_y_reg     <= new_y_reg;
                old_click_reg <= new_click_reg;
                drawn_reg     <= 1'b1;
                state_reg     <= IDLE;
                busy          <= 1'b0;
              end
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cursor_drawer.sv
// Scoreboard bench: a screen-level model queues the expected pixel and click
// stream per transaction; an independent monitor pops and compares.
module tb_cursor_drawer;

  localparam int W  = 160;
  localparam int H  = 120;
  localparam int S  = 5;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] mouse_x = 9'd0;
  logic [8:0] mouse_y = 9'd0;
  logic       l_click = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       click_pulse;
  logic [7:0] click_x;
  logic [6:0] click_y;

  cursor_drawer dut (
    .clock       (clock),
    .reset       (reset),
    .mouse_x     (mouse_x),
    .mouse_y     (mouse_y),
    .l_click     (l_click),
    .enable      (enable),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_colour  (vga_colour),
    .vga_plot    (vga_plot),
    .busy        (busy),
    .click_pulse (click_pulse),
    .click_x     (click_x),
    .click_y     (click_y)
  );

  always #5 clock = ~clock;

  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  pix_t exp_q[$];
  pix_t click_q[$];
  int   checks = 0;
  int   failures = 0;
  int   plots_seen = 0;

  // Screen-level model of what the cursor currently looks like.
  bit   m_drawn = 0;
  bit   m_prev = 0;
  bit   m_click = 0;
  int   m_x = 0;
  int   m_y = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int push_square(input int x, input int y, input int c);
    int n = 0;
    for (int r = 0; r < S; r++)
      for (int k = 0; k < S; k++)
        if (x + k < W && y + r < H) begin
          exp_q.push_back('{x + k, y + r, c});
          n++;
        end
    return n;
  endfunction

  task automatic model_apply(input int mx, input int my, input bit c,
                             output bit upd, output int erase_n, output int exp_cyc);
    int cx, cy;
    cx = (mx > W - 1) ? W - 1 : mx;
    cy = (my > H - 1) ? H - 1 : my;
    if (c && !m_prev) click_q.push_back('{cx, cy, 0});
    m_prev  = c;
    upd     = 0;
    erase_n = 0;
    exp_cyc = 0;
    if (!m_drawn || cx != m_x || cy != m_y || c != m_click) begin
      upd     = 1;
      exp_cyc = S * S;
      if (m_drawn) begin
        erase_n = push_square(m_x, m_y, 0);
        exp_cyc = 2 * S * S;
      end
      void'(push_square(cx, cy, c ? 4 : 7));
      m_drawn = 1;
      m_x     = cx;
      m_y     = cy;
      m_click = c;
    end
  endtask

  always @(negedge clock) begin : monitor
    pix_t e;
    if (vga_plot) begin
      plots_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL plot_extra actual=(%0d,%0d,%0d) required=none", vga_x, vga_y, vga_colour);
      end else begin
        e = exp_q.pop_front();
        if (int'(vga_x) != e.x || int'(vga_y) != e.y || int'(vga_colour) != e.c) begin
          failures++;
          $display("FAIL plot actual=(%0d,%0d,%0d) required=(%0d,%0d,%0d)",
                   vga_x, vga_y, vga_colour, e.x, e.y, e.c);
        end
      end
    end
    if (click_pulse) begin
      checks++;
      if (click_q.size() == 0) begin
        failures++;
        $display("FAIL click_extra actual=(%0d,%0d) required=none", click_x, click_y);
      end else begin
        e = click_q.pop_front();
        if (int'(click_x) != e.x || int'(click_y) != e.y) begin
          failures++;
          $display("FAIL click actual=(%0d,%0d) required=(%0d,%0d)", click_x, click_y, e.x, e.y);
        end
      end
    end
  end

  // mode 0: enable held, busy length checked; 1: random pauses;
  // 2: 10-cycle pause after 7th draw plot; 3: reset at 12th draw plot.
  task automatic wait_done(input bit upd, input int exp_cyc, input int mode,
                           input int draw_base, output bit did_reset);
    int busy_cyc = 0;
    int guard = 0;
    bit paused = 0;
    did_reset = 0;
    @(negedge clock); #1;
    check("busy_start", busy, upd);
    while (busy && guard < 1000) begin
      busy_cyc++;
      guard++;
      if (mode == 1) enable = ($urandom_range(0, 3) != 0);
      if (mode == 2 && !paused && plots_seen == draw_base + 7) begin
        paused = 1;
        enable = 0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clock); #1;
          check("gap_plot", vga_plot, 0);
          check("gap_busy", busy, 1);
        end
        enable = 1;
      end
      if (mode == 3 && plots_seen == draw_base + 12) begin
        reset = 1;
        @(negedge clock); #1;
        check("rst_plot", vga_plot, 0);
        check("rst_busy", busy, 0);
        exp_q.delete();
        click_q.delete();
        m_drawn = 0;
        m_prev = 0;
        did_reset = 1;
        return;
      end
      @(negedge clock); #1;
    end
    if (guard >= 1000) check("busy_timeout", guard, 0);
    if (mode == 0) check("busy_cycles", busy_cyc, exp_cyc);
    if (mode == 2) check("pause_taken", paused, 1);
    if (mode == 3) check("reset_taken", 0, 1);
    enable = 1;
    check("plots_left", exp_q.size(), 0);
    check("clicks_left", click_q.size(), 0);
  endtask

  task automatic run(input int mx, input int my, input bit c, input int mode);
    bit upd, rst;
    int en, ec, base, start;
    @(negedge clock); #1;
    mouse_x = 9'(mx);
    mouse_y = 9'(my);
    l_click = c;
    enable  = 1;
    start   = plots_seen;
    model_apply(mx, my, c, upd, en, ec);
    base = plots_seen + en;
    wait_done(upd, ec, mode, base, rst);
    if (rst) begin
      reset = 0;
      model_apply(mx, my, c, upd, en, ec);
      check("no_erase_after_reset", en, 0);
      base = plots_seen + en;
      wait_done(upd, ec, 0, base, rst);
    end
    $display("txn x=%0d y=%0d click=%0b mode=%0d plots=%0d", mx, my, c, mode, plots_seen - start);
  endtask

  task automatic do_reset();
    @(negedge clock); #1;
    reset  = 1;
    enable = 0;
    repeat (3) @(negedge clock);
    #1;
    exp_q.delete();
    click_q.delete();
    m_drawn = 0;
    m_prev  = 0;
    l_click = 0;
    reset   = 0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int rx, ry;
    bit rc;
    mouse_x = 9'd33;
    mouse_y = 9'd44;
    l_click = 1;
    repeat (3) @(negedge clock);
    #1;
    check("rst_vga_x", vga_x, 0);
    check("rst_vga_y", vga_y, 0);
    check("rst_colour", vga_colour, 0);
    check("rst_plot", vga_plot, 0);
    check("rst_busy", busy, 0);
    check("rst_click_pulse", click_pulse, 0);
    check("rst_click_x", click_x, 0);
    check("rst_click_y", click_y, 0);
    do_reset();

    run(10, 20, 0, 0);
    run(11, 20, 0, 0);
    run(11, 20, 0, 0);
    do_reset();
    run(300, 0, 0, 0);
    run(50, 60, 0, 0);
    run(50, 60, 1, 0);
    run(50, 60, 0, 0);
    do_reset();
    run(30, 40, 0, 2);
    run(70, 80, 0, 3);
    run(157, 118, 1, 0);

    rx = 0;
    ry = 0;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 4) != 0) begin
        rx = $urandom_range(0, 175);
        ry = $urandom_range(0, 135);
      end
      rc = 1'($urandom_range(0, 1));
      run(rx, ry, rc, int'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clock);
    #1;
    check("final_plots_left", exp_q.size(), 0);
    check("final_busy", busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
